player_lifecycle_ctrl: RTL
==========================

Name: player_lifecycle_ctrl

Overview:
Sequences the player ship through spawn, play, death and game-over.
- Gates keyboard move requests before they reach the player mover.
- Generates the player visibility/blink enable and fire requests (with cooldown).
- Issues the respawn pulse that returns the mover to its initial position.
- Sits between the keypad decoder and the player mover/drawer/missile blocks; all timing is counted in startOfFrame pulses.

Parameters:
INITIAL_LIVES, 3, lives loaded at reset
LIVES_WIDTH, 3, width of lives counter/output
INVULN_FRAMES, 60, frames of invulnerable blinking after each spawn
BLINK_HALF_FRAMES, 4, frames per visible/invisible half-period while in SPAWN
DEATH_FRAMES, 45, frames frozen and invisible after a hit
FIRE_COOLDOWN, 15, minimum frames between shots

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-clk pulse per frame
key_left, key_right, key_up, key_down  in  1 each  raw move requests
key_fire  in  1  fire key level
player_hit  in  1  one-clk collision pulse (enemy or bullet hit player)
move_left, move_right, move_up, move_down  out  1 each  gated move requests to mover
player_visible  out  1  drawing enable for player bitmap
fire_pulse  out  1  one-clk shot request to missile launcher
respawn  out  1  one-clk pulse; top level combines it into the mover's reset
lives_left  out  LIVES_WIDTH  remaining lives
game_over  out  1  high in GAME_OVER

Behaviour:
- Reset (async, resetN=0):
  - state=SPAWN; lives=INITIAL_LIVES; frame_cnt=0; cooldown=0; blink phase=visible.
  - All pulse outputs 0; player_visible=1; game_over=0.
- All outputs are registered; one-clk latency from input to output.
- Counters advance only on clk edges where startOfFrame=1.
- Move gating:
  - In SPAWN/ALIVE, move_x = key_x, except move_left=move_right=0 when both are pressed (same rule for up/down).
  - In DYING/GAME_OVER all move outputs are 0.
- SPAWN:
  - player_visible toggles every BLINK_HALF_FRAMES frames.
  - player_hit is ignored.
  - After INVULN_FRAMES frames: go to ALIVE, frame_cnt=0, player_visible=1.
- ALIVE:
  - player_visible=1.
  - player_hit=1: go to DYING, lives decrements (saturates at 0), frame_cnt=0.
- DYING:
  - player_visible=0; fire blocked.
  - After DEATH_FRAMES frames: if lives==0 go to GAME_OVER; else respawn=1 for exactly one clk and go to SPAWN with frame_cnt=0, blink visible.
- GAME_OVER:
  - game_over=1; all moves, fire and visibility are 0.
  - Only resetN exits this state.
- Fire:
  - fire_pulse=1 for one clk on a rising edge of key_fire, in SPAWN or ALIVE, when cooldown==0.
  - Cooldown is then loaded with FIRE_COOLDOWN and decrements on startOfFrame, saturating at 0.
  - Cooldown keeps counting through DYING.
- Simultaneous events:
  - player_hit and fire edge in the same clk in ALIVE: hit wins, no fire_pulse.
  - player_hit on the clk of the SPAWN->ALIVE transition is ignored.
  - player_hit while already DYING is ignored; no double decrement.
  - startOfFrame coincident with a state change: the counter restarts at 0 in the new state.
- Reset mid-operation: immediate return to reset values, including lives.

Optional Feature:
PLAYER_AUTOFIRE_EN
- Defined: key_fire held continuously produces fire_pulse each time cooldown reaches 0; the first shot still fires at press time.
- Undefined: a new rising edge of key_fire is required for every shot; holding the key fires once.

Decomposition:
- Shared package player_pkg:
  - state enum {SPAWN, ALIVE, DYING, GAME_OVER} as a 2-bit typedef player_state_t.
  - FRAME_CNT_WIDTH = 8 constant.
- One sub-module: frame_timer.
  - A loadable down-counter stepped by startOfFrame, with a done flag.
  - Instantiated twice: state timer and fire cooldown.

Test Plan:
- Reset, then 60 startOfFrame pulses -> player_visible toggles every 4 frames; state ALIVE after the 60th; player_visible=1; lives_left=3.
- In ALIVE, key_left=key_right=1 -> move_left=move_right=0; key_up alone -> move_up=1 the next clk.
- In ALIVE, player_hit pulse -> lives_left=2, all moves 0, player_visible=0. After 45 frames: respawn high exactly 1 clk, state SPAWN.
- Three hits, each after reaching ALIVE -> after the third DYING period game_over=1, lives_left=0, no respawn pulse; further player_hit and key activity have no effect.
- key_fire pressed twice 5 frames apart -> only the first fire_pulse. A third press at frame 16 -> fire_pulse. With PLAYER_AUTOFIRE_EN and key held 40 frames -> pulses at frames 0, 15 and 30.
- player_hit and key_fire rising edge in the same clk in ALIVE -> no fire_pulse; DYING entered. resetN asserted mid-DYING -> SPAWN, lives_left=3.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and constants for the player lifecycle controller.
package player_pkg;

    typedef enum logic [1:0] {
        SPAWN     = 2'd0,
        ALIVE     = 2'd1,
        DYING     = 2'd2,
        GAME_OVER = 2'd3
    } player_state_t;

    localparam int FRAME_CNT_WIDTH = 8;

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter stepped by startOfFrame; done_o is high while the count is zero.
module frame_timer
    import player_pkg::*;
#(
    parameter logic [FRAME_CNT_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       load_i,
    input  logic [FRAME_CNT_WIDTH-1:0] load_val_i,
    input  logic                       step_i,
    output logic                       done_o
);

    logic [FRAME_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (step_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - FRAME_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q <= RESET_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/player_lifecycle_ctrl.sv
// Player spawn/play/death/game-over sequencer with move gating, blink and fire cooldown.
// Build option: PLAYER_AUTOFIRE_EN makes a held fire key re-fire whenever the cooldown expires.
//
//   state     | meaning
//   SPAWN     | invulnerable, blinking, hits ignored
//   ALIVE     | visible, hit starts DYING
//   DYING     | frozen and invisible for DEATH_FRAMES
//   GAME_OVER | no lives left, held until reset
module player_lifecycle_ctrl
    import player_pkg::*;
#(
    parameter int INITIAL_LIVES     = 3,
    parameter int LIVES_WIDTH       = 3,
    parameter int INVULN_FRAMES     = 60,
    parameter int BLINK_HALF_FRAMES = 4,
    parameter int DEATH_FRAMES      = 45,
    parameter int FIRE_COOLDOWN     = 15
) (
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   startOfFrame,
    input  logic                   key_left,
    input  logic                   key_right,
    input  logic                   key_up,
    input  logic                   key_down,
    input  logic                   key_fire,
    input  logic                   player_hit,
    output logic                   move_left,
    output logic                   move_right,
    output logic                   move_up,
    output logic                   move_down,
    output logic                   player_visible,
    output logic                   fire_pulse,
    output logic                   respawn,
    output logic [LIVES_WIDTH-1:0] lives_left,
    output logic                   game_over
);

    // State timer is loaded with N-1 so the Nth frame pulse arrives on a zero count.
    localparam logic [FRAME_CNT_WIDTH-1:0] INVULN_LOAD = FRAME_CNT_WIDTH'(INVULN_FRAMES - 1);
    localparam logic [FRAME_CNT_WIDTH-1:0] DEATH_LOAD  = FRAME_CNT_WIDTH'(DEATH_FRAMES - 1);
    localparam logic [FRAME_CNT_WIDTH-1:0] BLINK_LOAD  = FRAME_CNT_WIDTH'(BLINK_HALF_FRAMES);
    localparam logic [FRAME_CNT_WIDTH-1:0] COOL_LOAD   = FRAME_CNT_WIDTH'(FIRE_COOLDOWN);
    localparam logic [FRAME_CNT_WIDTH-1:0] CNT_ONE     = FRAME_CNT_WIDTH'(1);
`ifdef PLAYER_AUTOFIRE_EN
    localparam logic AUTOFIRE = 1'b1;
`else
    localparam logic AUTOFIRE = 1'b0;
`endif

    player_state_t              state_q, state_d;
    logic [LIVES_WIDTH-1:0]     lives_q, lives_d;
    logic [FRAME_CNT_WIDTH-1:0] blink_cnt_q, blink_cnt_d;
    logic                       blink_q, blink_d;
    logic                       key_fire_q;
    logic [3:0]                 moves_q, moves_d;
    logic                       visible_q, visible_d;
    logic                       fire_q, fire_d;
    logic                       respawn_q, respawn_d;
    logic                       game_over_q, game_over_d;

    logic                       tmr_load, tmr_done, cool_done, frame_done, fire_req, can_move;
    logic [FRAME_CNT_WIDTH-1:0] tmr_load_val;

    frame_timer #(.RESET_VAL(INVULN_LOAD)) u_state_tmr (
        .clk        (clk),
        .resetN     (resetN),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .step_i     (startOfFrame),
        .done_o     (tmr_done)
    );

    frame_timer #(.RESET_VAL('0)) u_cool_tmr (
        .clk        (clk),
        .resetN     (resetN),
        .load_i     (fire_d),
        .load_val_i (COOL_LOAD),
        .step_i     (startOfFrame),
        .done_o     (cool_done)
    );

    assign frame_done = startOfFrame & tmr_done;
    assign fire_req   = key_fire & (AUTOFIRE | ~key_fire_q);

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        blink_d      = blink_q;
        blink_cnt_d  = blink_cnt_q;
        respawn_d    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        case (state_q)
            SPAWN: begin
                if (frame_done) begin
                    state_d = ALIVE;
                end else if (startOfFrame) begin
                    if (blink_cnt_q <= CNT_ONE) begin
                        blink_d     = ~blink_q;
                        blink_cnt_d = BLINK_LOAD;
                    end else begin
                        blink_cnt_d = blink_cnt_q - CNT_ONE;
                    end
                end
            end
            ALIVE: begin
                if (player_hit) begin
                    state_d = DYING;
                    lives_d = (lives_q == '0) ? '0 : lives_q - LIVES_WIDTH'(1);
                end
            end
            DYING: begin
                if (frame_done) begin
                    if (lives_q == '0) begin
                        state_d = GAME_OVER;
                    end else begin
                        state_d   = SPAWN;
                        respawn_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Any state change restarts the frame count, overriding a coincident frame step.
        if (state_d != state_q) begin
            tmr_load    = 1'b1;
            blink_d     = 1'b1;
            blink_cnt_d = BLINK_LOAD;
            if (state_d == SPAWN) begin
                tmr_load_val = INVULN_LOAD;
            end else if (state_d == DYING) begin
                tmr_load_val = DEATH_LOAD;
            end
        end

        can_move = (state_d == SPAWN) || (state_d == ALIVE);
        moves_d  = can_move ? {key_left & ~key_right, key_right & ~key_left,
                               key_up & ~key_down, key_down & ~key_up} : 4'b0000;

        case (state_d)
            SPAWN:   visible_d = blink_d;
            ALIVE:   visible_d = 1'b1;
            default: visible_d = 1'b0;
        endcase

        fire_d = fire_req & cool_done &
                 ((state_q == SPAWN) || ((state_q == ALIVE) && !player_hit));
        game_over_d = (state_d == GAME_OVER);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= SPAWN;
            lives_q     <= LIVES_WIDTH'(INITIAL_LIVES);
            blink_q     <= 1'b1;
            blink_cnt_q <= BLINK_LOAD;
            key_fire_q  <= 1'b0;
            moves_q     <= 4'b0000;
            visible_q   <= 1'b1;
            fire_q      <= 1'b0;
            respawn_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            key_fire_q  <= key_fire;
            moves_q     <= moves_d;
            visible_q   <= visible_d;
            fire_q      <= fire_d;
            respawn_q   <= respawn_d;
            game_over_q <= game_over_d;
        end
    end

    assign move_left      = moves_q[3];
    assign move_right     = moves_q[2];
    assign move_up        = moves_q[1];
    assign move_down      = moves_q[0];
    assign player_visible = visible_q;
    assign fire_pulse     = fire_q;
    assign respawn        = respawn_q;
    assign lives_left     = lives_q;
    assign game_over      = game_over_q;

endmodule
